// File: rtl/decode_ctrl_stage_if.sv
// rtl/decode_ctrl_stage_if.sv - fetch-to-rename bundle handshake for decode_ctrl_stage
interface decode_ctrl_stage_if #(
   parameter int WAYS   = 2,
   parameter int INST_W = 16,
   parameter int CTRL_W = 21
);
   logic                     flush;
   logic                     in_vld;
   logic                     in_rdy;
   logic [WAYS*INST_W-1:0]   inst_in;
   logic                     out_vld;
   logic                     out_rdy;
   logic [WAYS*INST_W-1:0]   inst_out;
   logic [WAYS*CTRL_W-1:0]   ctrl_out;

   modport master (
      output flush, in_vld, inst_in, out_rdy,
      input  in_rdy, out_vld, inst_out, ctrl_out
   );

   modport slave (
      input  flush, in_vld, inst_in, out_rdy,
      output in_rdy, out_vld, inst_out, ctrl_out
   );
endinterface

// File: rtl/decode_ctrl_stage.sv
// rtl/decode_ctrl_stage.sv - registered multi-way control decoder with one-entry skid buffer
// Optional JALR decode (opcode 1111, jmp_off 11) enabled by defining DECODE_JALR_EN.
module decode_ctrl_stage #(
   parameter int WAYS   = 2,
   parameter int INST_W = 16,
   parameter int CTRL_W = 21
) (
   input  logic                 clk,
   input  logic                 rst,
   decode_ctrl_stage_if.slave   bus
);
   localparam int B_LDI    = 20;
   localparam int B_BRN    = 18;
   localparam int B_JMP    = 16;
   localparam int B_MEMRD  = 15;
   localparam int B_MEMWR  = 14;
   localparam int B_ALU    = 11;
   localparam int B_INVRT  = 10;
   localparam int B_RS     = 9;
   localparam int B_RD     = 8;
   localparam int B_RT     = 7;
   localparam int B_IM     = 6;
   localparam int B_REGWR  = 5;
   localparam int B_JMPV   = 4;
   localparam int B_ADD    = 3;
   localparam int B_MULT   = 2;
   localparam int B_ADDR   = 1;
   localparam int B_VLD    = 0;

   // Argument is {opcode, jmp_off}: the only instruction bits the decode depends on.
   function automatic logic [CTRL_W-1:0] decode(input logic [5:0] hdr);
      logic [CTRL_W-1:0] c;
      logic [3:0]        op;
      logic [1:0]        jo;
      c  = '0;
      op = hdr[5:2];
      jo = hdr[1:0];
      case (op)
         4'h0: c = '0;
         4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
            c[B_ALU +: 3] = op[2:0];
            c[B_RS] = 1'b1; c[B_RD] = 1'b1; c[B_REGWR] = 1'b1;
            c[B_ADD] = 1'b1; c[B_VLD] = 1'b1;
            c[B_RT]    = (op != 4'h6);
            c[B_INVRT] = (op == 4'h2);
         end
         4'h8: begin
            c[B_RS] = 1'b1; c[B_RD] = 1'b1; c[B_RT] = 1'b1;
            c[B_REGWR] = 1'b1; c[B_MULT] = 1'b1; c[B_VLD] = 1'b1;
         end
         4'h9, 4'hA, 4'hB: begin
            c[B_BRN +: 2] = (op == 4'h9) ? 2'b11 : (op == 4'hA) ? 2'b01 : 2'b10;
            c[B_RS] = 1'b1; c[B_IM] = 1'b1; c[B_VLD] = 1'b1;
         end
         4'hC: begin
            c[B_LDI] = 1'b1; c[B_RD] = 1'b1; c[B_IM] = 1'b1;
            c[B_REGWR] = 1'b1; c[B_ADD] = 1'b1; c[B_VLD] = 1'b1;
         end
         4'hD: begin
            c[B_MEMWR] = 1'b1; c[B_RS] = 1'b1; c[B_RT] = 1'b1;
            c[B_IM] = 1'b1; c[B_ADDR] = 1'b1; c[B_VLD] = 1'b1;
         end
         4'hE: begin
            c[B_MEMRD] = 1'b1; c[B_RS] = 1'b1; c[B_RD] = 1'b1; c[B_IM] = 1'b1;
            c[B_REGWR] = 1'b1; c[B_ADDR] = 1'b1; c[B_VLD] = 1'b1;
         end
         default: begin
            case (jo)
               2'b00: begin
                  c[B_IM] = 1'b1; c[B_JMPV] = 1'b1; c[B_VLD] = 1'b1;
               end
               2'b01: begin
                  c[B_JMP +: 2] = 2'b01;
                  c[B_RS] = 1'b1; c[B_IM] = 1'b1; c[B_JMPV] = 1'b1; c[B_VLD] = 1'b1;
               end
               2'b10: begin
                  c[B_LDI] = 1'b1; c[B_JMP +: 2] = 2'b10;
                  c[B_RD] = 1'b1; c[B_IM] = 1'b1; c[B_REGWR] = 1'b1;
                  c[B_JMPV] = 1'b1; c[B_ADD] = 1'b1; c[B_VLD] = 1'b1;
               end
               default: begin
`ifdef DECODE_JALR_EN
                  c[B_JMP +: 2] = 2'b11;
                  c[B_RS] = 1'b1; c[B_RD] = 1'b1; c[B_IM] = 1'b1;
                  c[B_REGWR] = 1'b1; c[B_JMPV] = 1'b1; c[B_VLD] = 1'b1;
`else
                  c = '0;
`endif
               end
            endcase
         end
      endcase
      return c;
   endfunction

   logic [WAYS*CTRL_W-1:0] in_ctrl;
   logic [CTRL_W-1:0]      raw;
   logic                   shadow;

   // Ways above the first taken jump in the bundle are on the wrong path.
   always_comb begin
      in_ctrl = '0;
      raw     = '0;
      shadow  = 1'b0;
      for (int k = 0; k < WAYS; k++) begin
         raw = decode(bus.inst_in[k*INST_W + INST_W - 6 +: 6]);
         if (!shadow) in_ctrl[k*CTRL_W +: CTRL_W] = raw;
         if (raw[B_JMPV]) shadow = 1'b1;
      end
   end

   logic                   m_vld, s_vld;
   logic [WAYS*INST_W-1:0] m_inst, s_inst;
   logic [WAYS*CTRL_W-1:0] m_ctrl, s_ctrl;
   logic                   accept, drain;

   assign accept = bus.in_vld & ~s_vld & ~bus.flush;
   assign drain  = m_vld & bus.out_rdy;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_vld  <= 1'b0;
         s_vld  <= 1'b0;
         m_inst <= '0;
         m_ctrl <= '0;
         s_inst <= '0;
         s_ctrl <= '0;
      end else if (bus.flush) begin
         m_vld <= 1'b0;
         s_vld <= 1'b0;
      end else if (!m_vld || drain) begin
         // Accept implies skid empty, so at most one of these sources is live.
         if (s_vld) begin
            m_vld  <= 1'b1;
            m_inst <= s_inst;
            m_ctrl <= s_ctrl;
            s_vld  <= 1'b0;
         end else if (accept) begin
            m_vld  <= 1'b1;
            m_inst <= bus.inst_in;
            m_ctrl <= in_ctrl;
         end else begin
            m_vld <= 1'b0;
         end
      end else if (accept) begin
         s_vld  <= 1'b1;
         s_inst <= bus.inst_in;
         s_ctrl <= in_ctrl;
      end
   end

   assign bus.in_rdy   = ~s_vld;
   assign bus.out_vld  = m_vld;
   assign bus.inst_out = m_inst;
   assign bus.ctrl_out = m_ctrl;
endmodule

// File: tb/tb_decode_ctrl_stage.sv
// tb/tb_decode_ctrl_stage.sv - directed self-checking bench for decode_ctrl_stage
module tb_decode_ctrl_stage;
   localparam int WAYS   = 2;
   localparam int INST_W = 16;
   localparam int CTRL_W = 21;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   decode_ctrl_stage_if #(.WAYS(WAYS), .INST_W(INST_W), .CTRL_W(CTRL_W)) bif ();

   decode_ctrl_stage #(.WAYS(WAYS), .INST_W(INST_W), .CTRL_W(CTRL_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Decode vectors: {way1, way0} instructions and expected ctrl words.
   localparam int NV = 12;
   logic [15:0] v_i0 [NV] = '{16'h1123, 16'hF000, 16'h9000, 16'h1123, 16'hF400, 16'hF800,
                              16'h6000, 16'h8000, 16'hD000, 16'hA000, 16'h0000, 16'hFC00};
   logic [15:0] v_i1 [NV] = '{16'h2456, 16'h1123, 16'h1123, 16'hF000, 16'h1123, 16'h8000,
                              16'h7000, 16'hC000, 16'hE000, 16'hB000, 16'h1123, 16'h1123};
`ifdef DECODE_JALR_EN
   logic [20:0] v_c0 [NV] = '{21'h00BA9, 21'h00051, 21'hC0241, 21'h00BA9, 21'h10251, 21'h120179,
                              21'h03329, 21'h003A5, 21'h042C3, 21'h40241, 21'h00000, 21'h30371};
   logic [20:0] v_c1 [NV] = '{21'h017A9, 21'h00000, 21'h00BA9, 21'h00051, 21'h00000, 21'h00000,
                              21'h03BA9, 21'h100169, 21'h08363, 21'h80241, 21'h00BA9, 21'h00000};
`else
   logic [20:0] v_c0 [NV] = '{21'h00BA9, 21'h00051, 21'hC0241, 21'h00BA9, 21'h10251, 21'h120179,
                              21'h03329, 21'h003A5, 21'h042C3, 21'h40241, 21'h00000, 21'h00000};
   logic [20:0] v_c1 [NV] = '{21'h017A9, 21'h00000, 21'h00BA9, 21'h00051, 21'h00000, 21'h00000,
                              21'h03BA9, 21'h100169, 21'h08363, 21'h80241, 21'h00BA9, 21'h00BA9};
`endif

   initial begin
      bif.flush   = 1'b0;
      bif.in_vld  = 1'b0;
      bif.inst_in = '0;
      bif.out_rdy = 1'b1;
      #3;
      chk("rst_out_vld", 64'(bif.out_vld), 64'd0);
      chk("rst_in_rdy", 64'(bif.in_rdy), 64'd1);
      chk("rst_ctrl", 64'(bif.ctrl_out), 64'd0);
      chk("rst_inst", 64'(bif.inst_out), 64'd0);
      step();
      rst = 1'b0;
      step();
      chk("idle_out_vld", 64'(bif.out_vld), 64'd0);

      // Back-to-back decode at full throughput.
      for (int i = 0; i < NV; i++) begin
         bif.in_vld  = 1'b1;
         bif.inst_in = {v_i1[i], v_i0[i]};
         step();
         chk($sformatf("dec%0d_vld", i), 64'(bif.out_vld), 64'd1);
         chk($sformatf("dec%0d_inst", i), 64'(bif.inst_out), 64'({v_i1[i], v_i0[i]}));
         chk($sformatf("dec%0d_way0", i), 64'(bif.ctrl_out[20:0]), 64'(v_c0[i]));
         chk($sformatf("dec%0d_way1", i), 64'(bif.ctrl_out[41:21]), 64'(v_c1[i]));
      end
      bif.in_vld = 1'b0;
      step();
      chk("drain_out_vld", 64'(bif.out_vld), 64'd0);

      // Back-pressure: A to main, B to skid, C held off.
      bif.out_rdy = 1'b0;
      bif.in_vld  = 1'b1;
      bif.inst_in = 32'hA00A_A00A;
      step();
      chk("bp_a_inst", 64'(bif.inst_out), 64'hA00A_A00A);
      chk("bp_a_rdy", 64'(bif.in_rdy), 64'd1);
      bif.inst_in = 32'hB00B_B00B;
      step();
      chk("bp_b_rdy", 64'(bif.in_rdy), 64'd0);
      chk("bp_b_hold", 64'(bif.inst_out), 64'hA00A_A00A);
      bif.inst_in = 32'hC00C_C00C;
      step();
      chk("bp_c_rdy", 64'(bif.in_rdy), 64'd0);
      chk("bp_c_hold", 64'(bif.inst_out), 64'hA00A_A00A);
      chk("bp_c_vld", 64'(bif.out_vld), 64'd1);
      bif.out_rdy = 1'b1;
      step();
      chk("bp_out_b", 64'(bif.inst_out), 64'hB00B_B00B);
      chk("bp_b_rdy_again", 64'(bif.in_rdy), 64'd1);
      step();
      chk("bp_out_c", 64'(bif.inst_out), 64'hC00C_C00C);
      chk("bp_out_c_vld", 64'(bif.out_vld), 64'd1);
      bif.in_vld = 1'b0;
      step();
      chk("bp_empty", 64'(bif.out_vld), 64'd0);

      // Flush with both entries full and a bundle offered.
      bif.out_rdy = 1'b0;
      bif.in_vld  = 1'b1;
      bif.inst_in = 32'h1111_1111;
      step();
      bif.inst_in = 32'h2222_2222;
      step();
      chk("fl_full_rdy", 64'(bif.in_rdy), 64'd0);
      bif.flush   = 1'b1;
      bif.inst_in = 32'hDDDD_DDDD;
      step();
      chk("fl_out_vld", 64'(bif.out_vld), 64'd0);
      chk("fl_in_rdy", 64'(bif.in_rdy), 64'd1);
      bif.flush   = 1'b0;
      bif.in_vld  = 1'b0;
      bif.out_rdy = 1'b1;
      step();
      chk("fl_no_ghost0", 64'(bif.out_vld), 64'd0);
      step();
      chk("fl_no_ghost1", 64'(bif.out_vld), 64'd0);

      // Asynchronous reset mid-transfer.
      bif.out_rdy = 1'b0;
      bif.in_vld  = 1'b1;
      bif.inst_in = 32'h2456_1123;
      step();
      chk("ar_pre_vld", 64'(bif.out_vld), 64'd1);
      bif.inst_in = 32'h1123_F000;
      step();
      #2;
      rst = 1'b1;
      #1;
      chk("ar_out_vld", 64'(bif.out_vld), 64'd0);
      chk("ar_ctrl", 64'(bif.ctrl_out), 64'd0);
      chk("ar_inst", 64'(bif.inst_out), 64'd0);
      chk("ar_in_rdy", 64'(bif.in_rdy), 64'd1);
      step();
      rst = 1'b0;
      bif.in_vld = 1'b0;
      step();
      chk("ar_after_vld", 64'(bif.out_vld), 64'd0);
      chk("ar_after_rdy", 64'(bif.in_rdy), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
